dmem_arbiter: RTL and testbench
===============================

Name: dmem_arbiter

Overview:
- Shares the single byte-addressed data memory between two requesters: port 0 is the CPU load/store unit, port 1 is the memory loader/DMA.
- Uses round-robin arbitration with a bounded lock (burst) option for port 1.
- Registers each accepted request, drives the memory for exactly one cycle, and returns a registered response with error flagging for misaligned word accesses.
- Sits between the core/loader and the data memory. Its memory-side ports connect directly to the memory's we/ByteOp/Address/WriteData/ReadData.

Parameters:
- ADDRESS_WIDTH, 32, address width of requests and memory.
- DATA_WIDTH, 32, data width.
- LOCK_MAX, 8, maximum consecutive locked grants to port 1 before port 0 is served; must be >= 1.

Ports:
- clk  in  1  clock, all state updates on posedge.
- rst  in  1  synchronous active-high reset.
- req_valid  in  2  per-port request valid, bit i = port i.
- req_ready  out  2  per-port accept, one-hot or zero.
- req_we  in  2  per-port write enable.
- req_byte  in  2  per-port byte access (1) or word access (0).
- req_lock  in  1  port 1 requests burst lock.
- req_addr0, req_addr1  in  ADDRESS_WIDTH  request addresses.
- req_wdata0, req_wdata1  in  DATA_WIDTH  write data; only bits [7:0] are used for byte writes.
- rsp_valid  out  2  one-cycle response pulse per port, for both reads and writes.
- rsp_err  out  1  the response in this cycle is a misaligned-word error.
- rsp_rdata  out  DATA_WIDTH  read data for the port flagged in rsp_valid.
- mem_we  out  1  memory write enable.
- mem_byteop  out  1  memory byte-operation select.
- mem_addr  out  ADDRESS_WIDTH  memory address.
- mem_wdata  out  DATA_WIDTH  memory write data.
- mem_rdata  in  DATA_WIDTH  memory combinational read data.

Behaviour:
- Clock is clk; reset is rst, synchronous, active-high. rst has priority over all other events.
- Reset values:
  - Outputs: rsp_valid=0, rsp_err=0, rsp_rdata=0, req_ready=0, mem_we=0.
  - Internal: state=IDLE, last_grant=1 (so port 0 wins the first tie), lock_cnt=0.
- IDLE state:
  - req_ready is combinational from the grant decision; at most one bit is set.
  - On valid&ready, the holding register latches {port, we, byte, addr, wdata} and next state is ACCESS.
  - With no request valid: req_ready=0 and the state stays IDLE.
- Grant decision (IDLE only):
  - Only one port valid: grant it.
  - Both valid and locked (req_lock=1, last_grant=1, lock_cnt<LOCK_MAX): grant port 1.
  - Both valid otherwise: grant the port != last_grant.
- Lock counter:
  - lock_cnt increments on each port-1 grant made with req_lock=1.
  - It clears on any port-0 grant, or on a port-1 grant with req_lock=0.
  - With only port 1 valid, port 1 is granted even when lock_cnt=LOCK_MAX; the counter saturates at LOCK_MAX.
- ACCESS state, exactly one cycle:
  - mem_addr, mem_byteop and mem_wdata are driven from the holding register.
  - mem_we = hold_we & ~misaligned & ~rst.
  - misaligned = ~hold_byte & (hold_addr[1:0] != 0). A misaligned write never reaches memory.
  - At the closing edge: rsp_rdata <= misaligned ? 0 : mem_rdata, rsp_err <= misaligned, rsp_valid[hold_port] <= 1. Next state is IDLE.
- Outside ACCESS, mem_we=0 and mem_addr/mem_wdata/mem_byteop hold the last holding-register values.
- Timing:
  - Accept in cycle T, memory access in T+1, rsp_valid in T+2.
  - rsp_valid is one cycle wide; rsp_rdata and rsp_err hold until the next response.
  - A new request may be accepted in T+2, so throughput is 1 transaction per 2 cycles.
- Byte reads return mem_rdata unmodified (zero-extended byte). Sign extension belongs to the core.
- Write responses carry rsp_rdata = mem_rdata sampled at the write edge (pre-write contents). This is don't-care for requesters.
- Reset mid-operation:
  - rst asserted during ACCESS suppresses mem_we in that cycle, so no write commits on a reset edge.
  - The pending response is dropped: rsp_valid=0 next cycle.
  - Requesters must reissue after reset.
- Requesters must hold their request stable until req_ready. The block does not check for changes to a request before acceptance.

Decomposition:
- Package dmem_arb_pkg holds:
  - the state_t enum {IDLE, ACCESS};
  - port constants PORT_CPU=0 and PORT_LOAD=1;
  - the hold_req_t packed struct {port, we, byte, addr, wdata}.
- Sub-module rr_arb2 contains the grant logic, last_grant and lock_cnt registers, taking valid[1:0], lock and accept as inputs.
- The top level keeps the FSM, holding register, misalignment check and response register.

Test Plan:
- CPU word write then read: port 0 writes 0xDEADBEEF to 0x100, then reads 0x100. Required: mem_we high exactly one cycle (T+1); rsp_valid=2'b01 at T+2 for both; read rsp_rdata=0xDEADBEEF, rsp_err=0.
- Byte path: port 1 byte-writes 0xAB to 0x103, then port 0 byte-reads 0x103. Required: mem_byteop=1 in ACCESS; rsp_rdata=0x000000AB.
- Tie round-robin: both ports valid continuously with no lock. Required grants 0,1,0,1 from reset, and one accept every 2 cycles.
- Bounded lock: both valid, req_lock=1, LOCK_MAX=3. Required grant order 0,1,1,1,0,1,1,1; lock_cnt clears on each port-0 grant.
- Misaligned word write: port 0 writes to 0x102. Required: mem_we=0 throughout, rsp_valid[0]=1, rsp_err=1, rsp_rdata=0; memory at 0x100..0x103 unchanged.
- Reset in ACCESS: assert rst during the ACCESS cycle of a write to 0x200. Required: memory at 0x200 unchanged, no rsp_valid, state IDLE, and port 0 wins the next tie.

Source files
------------

// File: rtl/dmem_arb_pkg.sv
// Shared types for the data-memory arbiter: FSM states, port ids and the
// captured-request record.
package dmem_arb_pkg;

  localparam int HOLD_AW = 32;
  localparam int HOLD_DW = 32;

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } state_t;

  localparam logic PORT_CPU  = 1'b0;
  localparam logic PORT_LOAD = 1'b1;

  typedef struct packed {
    logic               port;
    logic               we;
    logic               byte_op;
    logic [HOLD_AW-1:0] addr;
    logic [HOLD_DW-1:0] wdata;
  } hold_req_t;

  // Word accesses must sit on a 4-byte boundary; byte accesses never fault.
  function automatic logic is_misaligned(input logic byte_op, input logic [1:0] addr_lsb);
    return ~byte_op & (addr_lsb != 2'b00);
  endfunction

endpackage

// File: rtl/dmem_arbiter_if.sv
// Requester, response and memory-side signals of the data-memory arbiter.
interface dmem_arbiter_if #(
  parameter int ADDRESS_WIDTH = 32,
  parameter int DATA_WIDTH    = 32
);
  logic [1:0]               req_valid;
  logic [1:0]               req_ready;
  logic [1:0]               req_we;
  logic [1:0]               req_byte;
  logic                     req_lock;
  logic [ADDRESS_WIDTH-1:0] req_addr0;
  logic [ADDRESS_WIDTH-1:0] req_addr1;
  logic [DATA_WIDTH-1:0]    req_wdata0;
  logic [DATA_WIDTH-1:0]    req_wdata1;
  logic [1:0]               rsp_valid;
  logic                     rsp_err;
  logic [DATA_WIDTH-1:0]    rsp_rdata;
  logic                     mem_we;
  logic                     mem_byteop;
  logic [ADDRESS_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0]    mem_wdata;
  logic [DATA_WIDTH-1:0]    mem_rdata;

  modport slave (
    input  req_valid, req_we, req_byte, req_lock, req_addr0, req_addr1,
           req_wdata0, req_wdata1, mem_rdata,
    output req_ready, rsp_valid, rsp_err, rsp_rdata,
           mem_we, mem_byteop, mem_addr, mem_wdata
  );

  modport master (
    output req_valid, req_we, req_byte, req_lock, req_addr0, req_addr1,
           req_wdata0, req_wdata1, mem_rdata,
    input  req_ready, rsp_valid, rsp_err, rsp_rdata,
           mem_we, mem_byteop, mem_addr, mem_wdata
  );
endinterface

// File: rtl/rr_arb2.sv
// Two-way round-robin grant with a bounded burst lock for the loader port.
module rr_arb2
  import dmem_arb_pkg::*;
#(
  parameter int LOCK_MAX = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] i_valid,
  input  logic       i_lock,
  input  logic       i_accept,
  output logic [1:0] o_grant
);
  localparam int CW = $clog2(LOCK_MAX + 1);

  logic          r_last_grant;
  logic [CW-1:0] r_lock_cnt;
  logic          w_locked;

  assign w_locked = i_lock & r_last_grant & (r_lock_cnt < CW'(LOCK_MAX));

  always_comb begin
    o_grant = 2'b00;
    if (i_accept) begin
      unique case (i_valid)
        2'b01:   o_grant[PORT_CPU]  = 1'b1;
        2'b10:   o_grant[PORT_LOAD] = 1'b1;
        2'b11: begin
          if (w_locked) o_grant[PORT_LOAD]     = 1'b1;
          else          o_grant[~r_last_grant] = 1'b1;
        end
        default: o_grant = 2'b00;
      endcase
    end
  end

  // The counter saturates so a lone locked loader keeps being served.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_last_grant <= 1'b1;
      r_lock_cnt   <= '0;
    end else if (|o_grant) begin
      r_last_grant <= o_grant[PORT_LOAD];
      if (o_grant[PORT_LOAD] & i_lock) begin
        if (r_lock_cnt != CW'(LOCK_MAX)) r_lock_cnt <= r_lock_cnt + CW'(1);
      end else begin
        r_lock_cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares one byte-addressed data memory between the CPU LSU (port 0) and the
// loader/DMA (port 1): accept, one memory cycle, then a registered response.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int ADDRESS_WIDTH = 32,
  parameter int DATA_WIDTH    = 32,
  parameter int LOCK_MAX      = 8
) (
  input  logic           clk,
  input  logic           rst,
  dmem_arbiter_if.slave  bus
);
  state_t                r_state;
  state_t                w_state_next;
  hold_req_t             r_hold;
  logic [1:0]            w_grant;
  logic                  w_accept;
  logic                  w_sel_load;
  logic                  w_misaligned;
  logic                  w_in_access;
  logic [1:0]            r_rsp_valid;
  logic                  r_rsp_err;
  logic [DATA_WIDTH-1:0] r_rsp_rdata;

  assign w_accept    = (r_state == IDLE) & ~rst;
  assign w_in_access = (r_state == ACCESS);

  rr_arb2 #(.LOCK_MAX(LOCK_MAX)) u_rr_arb2 (
    .clk      (clk),
    .rst      (rst),
    .i_valid  (bus.req_valid),
    .i_lock   (bus.req_lock),
    .i_accept (w_accept),
    .o_grant  (w_grant)
  );

  assign bus.req_ready = w_grant;
  assign w_sel_load    = w_grant[PORT_LOAD];

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      IDLE:    if (|w_grant) w_state_next = ACCESS;
      ACCESS:  w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_next;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_hold <= '0;
    end else if (|w_grant) begin
      r_hold <= '{
        port:    w_sel_load,
        we:      bus.req_we[w_sel_load],
        byte_op: bus.req_byte[w_sel_load],
        addr:    HOLD_AW'(w_sel_load ? bus.req_addr1 : bus.req_addr0),
        wdata:   HOLD_DW'(w_sel_load ? bus.req_wdata1 : bus.req_wdata0)
      };
    end
  end

  assign w_misaligned = is_misaligned(r_hold.byte_op, r_hold.addr[1:0]);

  // Memory bus follows the holding register; only the write strobe is gated.
  assign bus.mem_we     = w_in_access & r_hold.we & ~w_misaligned & ~rst;
  assign bus.mem_byteop = r_hold.byte_op;
  assign bus.mem_addr   = ADDRESS_WIDTH'(r_hold.addr);
  assign bus.mem_wdata  = DATA_WIDTH'(r_hold.wdata);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rsp_valid <= 2'b00;
      r_rsp_err   <= 1'b0;
      r_rsp_rdata <= '0;
    end else begin
      r_rsp_valid <= 2'b00;
      if (w_in_access) begin
        r_rsp_valid[r_hold.port] <= 1'b1;
        r_rsp_err                <= w_misaligned;
        r_rsp_rdata              <= w_misaligned ? '0 : bus.mem_rdata;
      end
    end
  end

  assign bus.rsp_valid = r_rsp_valid;
  assign bus.rsp_err   = r_rsp_err;
  assign bus.rsp_rdata = r_rsp_rdata;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: a transaction-level model predicts grants,
// memory accesses and responses; a monitor checks the DUT against the queues.
module tb_dmem_arbiter;
  localparam int AW    = 32;
  localparam int DW    = 32;
  localparam int LM    = 3;
  localparam int MEMSZ = 1024;

  typedef struct {
    bit        port;
    bit        we;
    bit        bo;
    bit [31:0] addr;
    bit [31:0] wdata;
  } txn_t;

  typedef struct {
    int        due;
    bit        port;
    bit        err;
    bit [31:0] rdata;
  } exp_t;

  typedef struct {
    int        cyc;
    bit        we;
    bit        bo;
    bit [31:0] addr;
  } acc_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  dmem_arbiter_if #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  dmem_arbiter #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW), .LOCK_MAX(LM)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;

  bit        p_act [2];
  bit        p_we  [2];
  bit        p_bo  [2];
  bit [31:0] p_addr[2];
  bit [31:0] p_wd  [2];
  bit        lock;
  bit        mem_init;

  bit   [7:0] ref_mem [MEMSZ];
  logic [7:0] env_mem [MEMSZ];
  int   m_last;
  int   m_cnt;
  bit   pend_valid;
  txn_t pend;
  int   glog[$];
  exp_t rq[$];
  acc_t aq[$];

  // ---------------- memory device (environment) ----------------
  logic [9:0] wa;
  assign wa = bus.mem_addr[9:0];
  assign bus.mem_rdata = bus.mem_byteop ? {24'h0, env_mem[wa]}
                       : {env_mem[wa + 10'd3], env_mem[wa + 10'd2], env_mem[wa + 10'd1], env_mem[wa]};

  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < MEMSZ; i++) env_mem[i] <= ref_mem[i];
    end else if (bus.mem_we) begin
      env_mem[wa] <= bus.mem_wdata[7:0];
      if (!bus.mem_byteop) begin
        env_mem[wa + 10'd1] <= bus.mem_wdata[15:8];
        env_mem[wa + 10'd2] <= bus.mem_wdata[23:16];
        env_mem[wa + 10'd3] <= bus.mem_wdata[31:24];
      end
    end
  end

  // ---------------- reference model ----------------
  function automatic bit [31:0] ref_read(input bit bo, input bit [31:0] a);
    bit [9:0] w;
    w = a[9:0];
    if (bo) return {24'h0, ref_mem[w]};
    return {ref_mem[w + 10'd3], ref_mem[w + 10'd2], ref_mem[w + 10'd1], ref_mem[w]};
  endfunction

  task automatic ref_write(input bit bo, input bit [31:0] a, input bit [31:0] d);
    bit [9:0] w;
    w = a[9:0];
    ref_mem[w] = d[7:0];
    if (!bo) begin
      ref_mem[w + 10'd1] = d[15:8];
      ref_mem[w + 10'd2] = d[23:16];
      ref_mem[w + 10'd3] = d[31:24];
    end
  endtask

  // Grant rules: lone requester wins; a tie goes to the locked loader while its
  // burst budget lasts, otherwise to the port that did not win last time.
  function automatic int pick(input bit v0, input bit v1);
    if (v0 && !v1) return 0;
    if (v1 && !v0) return 1;
    if (!v0 && !v1) return -1;
    if (lock && m_last == 1 && m_cnt < LM) return 1;
    return 1 - m_last;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    vectors++;
    if (act !== expv) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, expv, cyc);
    end
  endtask

  task automatic bound_fail(input string nm);
    vectors++;
    miscompares++;
    $display("FAIL %s: cycle budget exhausted at cycle %0d", nm, cyc);
  endtask

  task automatic set_req(input int p, input bit we, input bit bo, input bit [31:0] a, input bit [31:0] d);
    p_act[p]  = 1'b1;
    p_we[p]   = we;
    p_bo[p]   = bo;
    p_addr[p] = a;
    p_wd[p]   = d;
  endtask

  task automatic rand_req(input int p);
    bit        bo;
    bit [31:0] a;
    bo = 1'($urandom_range(0, 1));
    a  = 32'($urandom_range(0, 127));
    if (!bo && $urandom_range(0, 3) != 0) a[1:0] = 2'b00;
    set_req(p, 1'($urandom_range(0, 1)), bo, a, $urandom);
  endtask

  task automatic step(input bit do_rst);
    int        g;
    bit [1:0]  exp_ready;
    bit        mis;
    bit [31:0] rd;
    @(negedge clk);
    cyc++;
    rst            = do_rst;
    bus.req_valid  = {p_act[1], p_act[0]};
    bus.req_we     = {p_we[1], p_we[0]};
    bus.req_byte   = {p_bo[1], p_bo[0]};
    bus.req_lock   = lock;
    bus.req_addr0  = p_addr[0];
    bus.req_addr1  = p_addr[1];
    bus.req_wdata0 = p_wd[0];
    bus.req_wdata1 = p_wd[1];
    exp_ready = 2'b00;
    if (do_rst) begin
      m_last     = 1;
      m_cnt      = 0;
      pend_valid = 1'b0;
    end else if (pend_valid) begin
      mis = !pend.bo && (pend.addr[1:0] != 2'b00);
      rd  = mis ? 32'h0 : ref_read(pend.bo, pend.addr);
      aq.push_back('{cyc: cyc, we: pend.we && !mis, bo: pend.bo, addr: pend.addr});
      rq.push_back('{due: cyc + 1, port: pend.port, err: mis, rdata: rd});
      if (pend.we && !mis) ref_write(pend.bo, pend.addr, pend.wdata);
      pend_valid = 1'b0;
    end else begin
      g = pick(p_act[0], p_act[1]);
      if (g >= 0) begin
        exp_ready[g] = 1'b1;
        pend = '{port: g[0], we: p_we[g], bo: p_bo[g], addr: p_addr[g], wdata: p_wd[g]};
        p_act[g] = 1'b0;
        if (g == 1 && lock) m_cnt = (m_cnt < LM) ? m_cnt + 1 : LM;
        else                m_cnt = 0;
        m_last = g;
        glog.push_back(g);
        pend_valid = 1'b1;
      end
    end
    #1;
    if (!do_rst) chk("req_ready", 32'(bus.req_ready), 32'(exp_ready));
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((p_act[0] || p_act[1] || pend_valid || rq.size() > 0) && n < 60) begin
      step(1'b0);
      n++;
    end
    if (n >= 60) bound_fail("drain");
  endtask

  // Keep both requesters busy until the grant log reaches the target length.
  task automatic run_ties(input int target, input bit refill0);
    int n;
    n = 0;
    while (glog.size() < target && n < 100) begin
      if (!p_act[0] && refill0) rand_req(0);
      if (!p_act[1]) rand_req(1);
      step(1'b0);
      n++;
    end
    if (n >= 100) bound_fail("tie_run");
  endtask

  // ---------------- monitor ----------------
  initial begin
    acc_t a;
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (aq.size() > 0 && aq[0].cyc == cyc) begin
        a = aq.pop_front();
        chk("mem_we", 32'(bus.mem_we), 32'(a.we));
        chk("mem_byteop", 32'(bus.mem_byteop), 32'(a.bo));
        chk("mem_addr", bus.mem_addr, a.addr);
      end else if (bus.mem_we) begin
        chk("mem_we_stray", 32'(bus.mem_we), 32'h0);
      end
      if (bus.rsp_valid != 2'b00 || (rq.size() > 0 && rq[0].due == cyc)) begin
        if (rq.size() == 0) begin
          chk("rsp_unexpected", 32'(bus.rsp_valid), 32'h0);
        end else begin
          e = rq.pop_front();
          chk("rsp_valid", 32'(bus.rsp_valid), 32'(2'b01 << e.port));
          chk("rsp_cycle", 32'(cyc), 32'(e.due));
          chk("rsp_err", 32'(bus.rsp_err), 32'(e.err));
          chk("rsp_rdata", bus.rsp_rdata, e.rdata);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  int exp_tie [4] = '{0, 1, 0, 1};
  int exp_lock[8] = '{0, 1, 1, 1, 0, 1, 1, 1};
  bit [31:0] d;
  int n;

  initial begin
    for (int i = 0; i < MEMSZ; i++) ref_mem[i] = 8'($urandom);
    for (int p = 0; p < 2; p++) set_req(p, 1'b0, 1'b0, 32'h0, 32'h0);
    p_act[0] = 1'b0;
    p_act[1] = 1'b0;
    lock = 1'b0;
    bus.req_valid = 2'b00;
    bus.req_we = 2'b00;
    bus.req_byte = 2'b00;
    bus.req_lock = 1'b0;
    bus.req_addr0 = '0;
    bus.req_addr1 = '0;
    bus.req_wdata0 = '0;
    bus.req_wdata1 = '0;
    mem_init = 1'b1;
    step(1'b1);
    mem_init = 1'b0;
    step(1'b1);
    // A request raised during reset must not be taken.
    set_req(0, 1'b1, 1'b0, 32'h100, 32'hDEADBEEF);
    step(1'b1);
    chk("rst_req_ready", 32'(bus.req_ready), 32'h0);
    chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'h0);
    chk("rst_rsp_err", 32'(bus.rsp_err), 32'h0);
    chk("rst_rsp_rdata", bus.rsp_rdata, 32'h0);
    chk("rst_mem_we", 32'(bus.mem_we), 32'h0);
    drain();
    set_req(0, 1'b0, 1'b0, 32'h100, $urandom);
    drain();

    d = $urandom;
    d[7:0] = 8'hAB;
    set_req(1, 1'b1, 1'b1, 32'h103, d);
    drain();
    set_req(0, 1'b0, 1'b1, 32'h103, $urandom);
    drain();

    step(1'b1);
    step(1'b1);
    glog.delete();
    run_ties(4, 1'b1);
    for (int k = 0; k < 4; k++)
      if (k < glog.size()) chk($sformatf("tie_grant%0d", k), 32'(glog[k]), 32'(exp_tie[k]));
    drain();

    step(1'b1);
    step(1'b1);
    glog.delete();
    rand_req(0);
    drain();
    lock = 1'b1;
    run_ties(8, 1'b1);
    for (int k = 0; k < 8; k++)
      if (k < glog.size()) chk($sformatf("lock_grant%0d", k), 32'(glog[k]), 32'(exp_lock[k]));
    drain();
    run_ties(14, 1'b0);
    drain();
    lock = 1'b0;

    set_req(0, 1'b1, 1'b0, 32'h102, $urandom);
    drain();

    set_req(0, 1'b1, 1'b0, 32'h200, 32'h12345678);
    n = 0;
    while (p_act[0] && n < 10) begin
      step(1'b0);
      n++;
    end
    if (n >= 10) bound_fail("accept_0x200");
    step(1'b1);
    step(1'b0);
    glog.delete();
    rand_req(0);
    rand_req(1);
    n = 0;
    while (glog.size() < 1 && n < 10) begin
      step(1'b0);
      n++;
    end
    if (glog.size() > 0) chk("post_reset_tie", 32'(glog[0]), 32'h0);
    else bound_fail("post_reset_tie");
    drain();

    repeat (600) begin
      for (int p = 0; p < 2; p++)
        if (!p_act[p] && $urandom_range(0, 2) == 0) rand_req(p);
      if (!p_act[1]) lock = 1'($urandom_range(0, 1));
      step(1'b0);
    end
    drain();
    step(1'b0);
    step(1'b0);

    chk("rsp_queue_empty", 32'(rq.size()), 32'h0);
    chk("acc_queue_empty", 32'(aq.size()), 32'h0);
    for (int i = 0; i < MEMSZ; i += 4)
      chk($sformatf("mem_image_%03h", i),
          {env_mem[i + 3], env_mem[i + 2], env_mem[i + 1], env_mem[i]},
          {ref_mem[i + 3], ref_mem[i + 2], ref_mem[i + 1], ref_mem[i]});

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
